// File: rtl/key_expansion.sv
// AES-256 key schedule: derives round keys 2..14, one 32-bit word per clock.
// Round keys 0 and 1 are the raw key halves and are not produced here.
module key_expansion (
    input  logic         input_start,
    input  logic         clock,
    input  logic [255:0] key,
    output logic [127:0] k1,
    output logic [127:0] k2,
    output logic [127:0] k3,
    output logic [127:0] k4,
    output logic [127:0] k5,
    output logic [127:0] k6,
    output logic [127:0] k7,
    output logic [127:0] k8,
    output logic [127:0] k9,
    output logic [127:0] k10,
    output logic [127:0] k11,
    output logic [127:0] k12,
    output logic [127:0] k13,
    output logic         finished,
    input  logic         reset_n
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX[a];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]),
                sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    state_t            state;
    logic [5:0]        idx;
    logic [31:0]       win [0:7];
    logic [0:3][31:0]  rk  [1:13];

    logic [31:0] rot;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] next_word;
    logic [7:0]  rcon;
    logic [3:0]  slot_key;

    // Derive the next schedule word from the window and the word index
    always_comb begin
        rot      = {win[7][23:0], win[7][31:24]};
        sub_in   = idx[2] ? win[7] : rot;
        sub_out  = sub_word(sub_in);
        rcon     = 8'h01 << (idx[5:3] - 3'd1);
        temp     = win[7];
        unique case (1'b1)
            (idx[2:0] == 3'd0): temp = sub_out ^ {rcon, 24'h0};
            (idx[2:0] == 3'd4): temp = sub_out;
            default:            temp = win[7];
        endcase
        next_word = win[0] ^ temp;
        slot_key  = idx[5:2] - 4'd1;
    end

    // Control FSM, sliding window and round-key registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            finished <= 1'b0;
            for (int j = 0; j < 8; j++) begin
                win[j] <= '0;
            end
            for (int n = 1; n <= 13; n++) begin
                rk[n] <= '0;
            end
        end else if (input_start) begin
            state    <= BUSY;
            idx      <= 6'd8;
            finished <= 1'b0;
            for (int j = 0; j < 8; j++) begin
                win[j] <= key[255 - 32*j -: 32];
            end
            for (int n = 1; n <= 13; n++) begin
                rk[n] <= '0;
            end
        end else if (state == BUSY) begin
            for (int j = 0; j < 7; j++) begin
                win[j] <= win[j+1];
            end
            win[7]                <= next_word;
            rk[slot_key][idx[1:0]] <= next_word;
            idx                   <= idx + 6'd1;
            if (idx == 6'd59) begin
                state    <= DONE;
                finished <= 1'b1;
            end
        end
    end

    assign k1  = rk[1];
    assign k2  = rk[2];
    assign k3  = rk[3];
    assign k4  = rk[4];
    assign k5  = rk[5];
    assign k6  = rk[6];
    assign k7  = rk[7];
    assign k8  = rk[8];
    assign k9  = rk[9];
    assign k10 = rk[10];
    assign k11 = rk[11];
    assign k12 = rk[12];
    assign k13 = rk[13];

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: scoreboard against a reference key schedule
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_key_expansion;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         input_start;
    logic [255:0] key;
    logic [127:0] k1, k2, k3, k4, k5, k6, k7;
    logic [127:0] k8, k9, k10, k11, k12, k13;
    logic         finished;

    typedef logic [12:0][127:0] keys_t;
    typedef struct {
        keys_t keys;
        int    cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_e;
    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    logic [7:0]  sb [256];
    logic        fin_q  = 1'b0;
    keys_t       dut_keys;

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    key_expansion dut (
        .input_start(input_start),
        .clock(clock),
        .key(key),
        .k1(k1), .k2(k2), .k3(k3), .k4(k4), .k5(k5),
        .k6(k6), .k7(k7), .k8(k8), .k9(k9), .k10(k10),
        .k11(k11), .k12(k12), .k13(k13),
        .finished(finished),
        .reset_n(reset_n)
    );

    assign dut_keys = {k13, k12, k11, k10, k9, k8, k7,
                       k6, k5, k4, k3, k2, k1};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                  ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic keys_t model(input logic [255:0] kv);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        keys_t       r;
        for (int i = 0; i < 8; i++) w[i] = kv[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int n = 0; n < 13; n++) begin
            r[n] = {w[4*n+8], w[4*n+9], w[4*n+10], w[4*n+11]};
        end
        return r;
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: each rising edge of finished retires one scoreboard entry
    always @(negedge clock) begin
        if (reset_n && finished && !fin_q) begin
            if (sb_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_finish: rose at cycle %0d, none pending", cyc);
            end else begin
                m_e = sb_q.pop_front();
                chk("finish_cycle", 128'(cyc), 128'(m_e.cyc));
                for (int n = 0; n < 13; n++) begin
                    chk($sformatf("k%0d", n + 1), dut_keys[n], m_e.keys[n]);
                end
            end
        end
        fin_q = finished;
    end

    task automatic start_run(input logic [255:0] kv, input int hold,
                             input bit push);
        exp_t e;
        @(negedge clock);
        key         = kv;
        input_start = 1'b1;
        repeat (hold) @(negedge clock);
        input_start = 1'b0;
        if (push) begin
            e.keys = model(kv);
            e.cyc  = cyc + 52;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            $display("FAIL timeout: %0d runs never finished, expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        keys_t    ka;
        logic [255:0] kv;
        build_sbox();
        reset_n     = 1'b1;
        input_start = 1'b0;
        key         = '0;
        #2 reset_n  = 1'b0;
        #1;
        chk("reset_finished", 128'(finished), 128'(0));
        chk("reset_k1", k1, 128'h0);
        chk("reset_k13", k13, 128'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        start_run(KEY_C3, 1, 1'b1);
        wait_idle();
        chk("c3_k1", k1, 128'ha573c29fa176c498a97fce93a572c09c);
        chk("c3_k2", k2, 128'h1651a8cd0244beda1a5da4c10640bade);
        chk("c3_k13", k13, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        key = rand_key();
        repeat (10) @(negedge clock);
        chk("hold_finished", 128'(finished), 128'(1));
        chk("hold_k1", k1, 128'ha573c29fa176c498a97fce93a572c09c);
        chk("hold_k13", k13, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        start_run(rand_key(), 3, 1'b1);
        wait_idle();

        start_run(KEY_A3, 1, 1'b1);
        wait_idle();
        chk("a3_k1", k1, 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("a3_k13", k13, 128'hfe4890d1e6188d0b046df344706c631e);

        start_run('0, 1, 1'b1);
        wait_idle();
        chk("zero_k1", k1, 128'h62636363626363636263636362636363);
        chk("zero_k2", k2, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);

        kv = rand_key();
        ka = model(kv);
        start_run(kv, 1, 1'b0);
        repeat (19) @(negedge clock);
        chk("restart_pre_k1", k1, ka[0]);
        start_run(rand_key(), 1, 1'b1);
        chk("restart_finished", 128'(finished), 128'(0));
        chk("restart_k1", k1, 128'h0);
        chk("restart_k13", k13, 128'h0);
        wait_idle();

        start_run(rand_key(), 1, 1'b1);
        chk("done_restart_finished", 128'(finished), 128'(0));
        wait_idle();

        for (int r = 0; r < 8; r++) begin
            start_run(rand_key(), int'($urandom_range(1, 3)), 1'b1);
            wait_idle();
        end

        start_run(rand_key(), 1, 1'b0);
        repeat (10) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_finished", 128'(finished), 128'(0));
        for (int n = 0; n < 13; n++) begin
            chk($sformatf("midrst_k%0d", n + 1), dut_keys[n], 128'h0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_k1", k1, 128'h0);
        chk("idle_finished", 128'(finished), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
